decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 52 +++++
 rtl/decode_logic.sv | 136 +++++++++++++
 rtl/decode_stage.sv | 148 ++++++++++++++
 tb/tb_decode_stage.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// rtl/decode_stage_pkg.sv - opcode constants, aluCtrl encoding, skid states and decoded bundle
package decode_stage_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP32   = 7'b0111011;

  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [4:0] ALU_R       = 5'd0;
  localparam logic [4:0] ALU_IARITH  = 5'd1;
  localparam logic [4:0] ALU_MEM     = 5'd2;
  localparam logic [4:0] ALU_BRANCH  = 5'd3;
  localparam logic [4:0] ALU_PCADD   = 5'd4;
  localparam logic [4:0] ALU_LUI     = 5'd5;
  localparam logic [4:0] ALU_MEXT    = 5'd6;
  localparam logic [4:0] ALU_ILLEGAL = 5'd31;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [4:0] alu_ctrl;
    logic       load;
    logic       store;
    logic       branch;
    logic       reg_write;
    logic       alu_src;
    logic       jal;
    logic       jalr;
    logic       auipc;
    logic       illegal;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } dec_t;

endpackage

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - pure combinational instruction decode
// Build option: DECODE_MEXT_EN decodes R-type funct7=0000001 as M-extension instead of illegal.
module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_t            dec,
  output logic [XLEN-1:0] imm
);

`ifdef DECODE_MEXT_EN
  localparam bit MEXT_EN = 1'b1;
`else
  localparam bit MEXT_EN = 1'b0;
`endif
  localparam bit W_FORMS = (XLEN == 64);

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic            bad;

  assign imm_i = XLEN'($signed(instr[31:20]));
  assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));

  // Fields a format does not use are left at zero.
  always_comb begin
    dec        = '0;
    imm        = '0;
    bad        = 1'b0;
    dec.opcode = instr[6:0];
    case (instr[6:0])
      OP_OP, OP_OP32: begin
        if (instr[6:0] == OP_OP32 && !W_FORMS) begin
          bad = 1'b1;
        end else if (instr[31:25] == F7_MEXT) begin
          if (MEXT_EN) dec.alu_ctrl = ALU_MEXT;
          else         bad = 1'b1;
        end else begin
          dec.alu_ctrl = ALU_R;
        end
        dec.reg_write = 1'b1;
        dec.funct7    = instr[31:25];
        dec.funct3    = instr[14:12];
        dec.rs1       = instr[19:15];
        dec.rs2       = instr[24:20];
        dec.rd        = instr[11:7];
      end
      OP_IMM, OP_IMM32: begin
        if (instr[6:0] == OP_IMM32 && !W_FORMS) bad = 1'b1;
        dec.alu_ctrl  = ALU_IARITH;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.funct3    = instr[14:12];
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        imm           = imm_i;
      end
      OP_LOAD: begin
        dec.alu_ctrl  = ALU_MEM;
        dec.load      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.funct3    = instr[14:12];
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        imm           = imm_i;
      end
      OP_STORE: begin
        dec.alu_ctrl = ALU_MEM;
        dec.store    = 1'b1;
        dec.alu_src  = 1'b1;
        dec.funct3   = instr[14:12];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        imm          = imm_s;
      end
      OP_BRANCH: begin
        dec.alu_ctrl = ALU_BRANCH;
        dec.branch   = 1'b1;
        dec.alu_src  = 1'b1;
        dec.funct3   = instr[14:12];
        dec.rs1      = instr[19:15];
        dec.rs2      = instr[24:20];
        imm          = imm_b;
      end
      OP_JAL: begin
        dec.alu_ctrl  = ALU_PCADD;
        dec.jal       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rd        = instr[11:7];
        imm           = imm_j;
      end
      OP_JALR: begin
        dec.alu_ctrl  = ALU_PCADD;
        dec.jalr      = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.funct3    = instr[14:12];
        dec.rs1       = instr[19:15];
        dec.rd        = instr[11:7];
        imm           = imm_i;
      end
      OP_LUI: begin
        dec.alu_ctrl  = ALU_LUI;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rd        = instr[11:7];
        imm           = imm_u;
      end
      OP_AUIPC: begin
        dec.alu_ctrl  = ALU_PCADD;
        dec.auipc     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.rd        = instr[11:7];
        imm           = imm_u;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) bad = 1'b1;
    // Illegal words still travel down the pipe with their opcode so the trap logic can see them.
    if (bad) begin
      dec          = '0;
      imm          = '0;
      dec.opcode   = instr[6:0];
      dec.illegal  = 1'b1;
      dec.alu_ctrl = ALU_ILLEGAL;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - decode stage with registered outputs and a two-entry skid buffer
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ID_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] in_pc,
  input  logic [ID_W-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      aluCtrl,
  output logic            load,
  output logic            store,
  output logic            branch,
  output logic            regWrite,
  output logic            aluSrc,
  output logic            JAL,
  output logic            JALR,
  output logic            AUIPC,
  output logic            illegal,
  output logic [6:0]      opCode,
  output logic [6:0]      funct7,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] out_pc,
  output logic [ID_W-1:0] out_tag
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("decode_stage: XLEN must be 32 or 64");
  end

  typedef struct packed {
    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [ID_W-1:0] tag;
  } entry_t;

  skid_state_e     state_q, state_d;
  entry_t          main_q, main_d, skid_q, skid_d, new_entry;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  dec_t            dec_w;
  logic [XLEN-1:0] imm_w;
  logic            accept, drain;

  decode_logic #(.XLEN(XLEN)) u_decode_logic (
    .instr (instruction),
    .dec   (dec_w),
    .imm   (imm_w)
  );

  assign new_entry.dec = dec_w;
  assign new_entry.imm = imm_w;
  assign new_entry.pc  = in_pc;
  assign new_entry.tag = in_tag;

  assign accept = in_valid && in_ready_q;
  assign drain  = out_valid_q && out_ready;

  // main_q is always the head of the queue; skid_q only holds a word while FULL.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (accept) begin
            main_d  = new_entry;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (accept && drain) begin
            main_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = SKID_FULL;
          end else if (drain) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (drain) begin
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    in_ready_d  = (state_d != SKID_FULL);
    out_valid_d = (state_d != SKID_EMPTY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SKID_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_q      <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign aluCtrl   = main_q.dec.alu_ctrl;
  assign load      = main_q.dec.load;
  assign store     = main_q.dec.store;
  assign branch    = main_q.dec.branch;
  assign regWrite  = main_q.dec.reg_write;
  assign aluSrc    = main_q.dec.alu_src;
  assign JAL       = main_q.dec.jal;
  assign JALR      = main_q.dec.jalr;
  assign AUIPC     = main_q.dec.auipc;
  assign illegal   = main_q.dec.illegal;
  assign opCode    = main_q.dec.opcode;
  assign funct7    = main_q.dec.funct7;
  assign funct3    = main_q.dec.funct3;
  assign rs1       = main_q.dec.rs1;
  assign rs2       = main_q.dec.rs2;
  assign rd        = main_q.dec.rd;
  assign imm       = main_q.imm;
  assign out_pc    = main_q.pc;
  assign out_tag   = main_q.tag;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (XLEN=32, ID_W=8)
module tb_decode_stage;

`ifdef DECODE_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [31:0] in_pc = '0;
  logic [7:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  aluCtrl;
  logic        load, store, branch, regWrite, aluSrc, JAL, JALR, AUIPC, illegal;
  logic [6:0]  opCode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, out_pc;
  logic [7:0]  out_tag;

  decode_stage #(.XLEN(32), .ID_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .in_pc(in_pc), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluCtrl(aluCtrl), .load(load), .store(store), .branch(branch),
    .regWrite(regWrite), .aluSrc(aluSrc), .JAL(JAL), .JALR(JALR), .AUIPC(AUIPC),
    .illegal(illegal), .opCode(opCode), .funct7(funct7), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .out_pc(out_pc), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [45:0] ctrl;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [7:0]  tag;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  int   pops = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [45:0] ctrl_obs;
  logic        hold_armed = 1'b0;
  logic [53:0] hold_ctrl;
  logic [63:0] hold_data;
  logic [31:0] pc_ctr = 32'h0000_1000;
  logic [7:0]  tag_ctr = 8'h01;

  assign ctrl_obs = {aluCtrl, load, store, branch, regWrite, aluSrc, JAL, JALR, AUIPC,
                     illegal, opCode, funct7, funct3, rs1, rs2, rd};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // fl = {load, store, branch, regWrite, aluSrc, JAL, JALR, AUIPC}
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc, input logic [7:0] tag);
    exp_t       e;
    logic [4:0] alu;
    logic [7:0] fl;
    logic       bad;
    byte        fmt;
    e = '0; alu = 5'd0; fl = 8'h00; bad = 1'b0; fmt = "X";
    case (w[6:0])
      7'h33: begin
        fmt = "R"; fl = 8'b0001_0000;
        if (w[31:25] == 7'h01) begin
          if (MEXT) alu = 5'd6;
          else bad = 1'b1;
        end
      end
      7'h13: begin fmt = "I"; alu = 5'd1; fl = 8'b0001_1000; end
      7'h03: begin fmt = "I"; alu = 5'd2; fl = 8'b1001_1000; end
      7'h23: begin fmt = "S"; alu = 5'd2; fl = 8'b0100_1000; end
      7'h63: begin fmt = "B"; alu = 5'd3; fl = 8'b0010_1000; end
      7'h6F: begin fmt = "J"; alu = 5'd4; fl = 8'b0001_1100; end
      7'h67: begin fmt = "I"; alu = 5'd4; fl = 8'b0001_1010; end
      7'h37: begin fmt = "U"; alu = 5'd5; fl = 8'b0001_1000; end
      7'h17: begin fmt = "U"; alu = 5'd4; fl = 8'b0001_1001; end
      default: bad = 1'b1;
    endcase
    if (w[1:0] != 2'b11) bad = 1'b1;
    if (bad) begin
      e.ctrl = {5'd31, 8'h00, 1'b1, w[6:0], 25'b0};
    end else begin
      case (fmt)
        "R": e.ctrl = {alu, fl, 1'b0, w[6:0], w[31:25], w[14:12], w[19:15], w[24:20], w[11:7]};
        "I": begin
          e.ctrl = {alu, fl, 1'b0, w[6:0], 7'b0, w[14:12], w[19:15], 5'b0, w[11:7]};
          e.imm  = {{20{w[31]}}, w[31:20]};
        end
        "S": begin
          e.ctrl = {alu, fl, 1'b0, w[6:0], 7'b0, w[14:12], w[19:15], w[24:20], 5'b0};
          e.imm  = {{20{w[31]}}, w[31:25], w[11:7]};
        end
        "B": begin
          e.ctrl = {alu, fl, 1'b0, w[6:0], 7'b0, w[14:12], w[19:15], w[24:20], 5'b0};
          e.imm  = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        end
        "J": begin
          e.ctrl = {alu, fl, 1'b0, w[6:0], 15'b0, 5'b0, w[11:7]};
          e.imm  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        end
        default: begin
          e.ctrl = {alu, fl, 1'b0, w[6:0], 15'b0, 5'b0, w[11:7]};
          e.imm  = {w[31:12], 12'b0};
        end
      endcase
    end
    e.pc  = pc;
    e.tag = tag;
    return e;
  endfunction

  // Inputs change at posedge+1, so at the negedge they show what the next edge will transfer.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      hold_armed <= 1'b0;
    end else begin
      if (hold_armed && out_valid) begin
        check("hold_ctrl", {ctrl_obs, out_tag}, hold_ctrl);
        check("hold_data", {imm, out_pc}, hold_data);
      end
      if (out_valid && out_ready && !flush) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 64'd1, 64'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("ctrl", ctrl_obs, mon_e.ctrl);
          check("imm", imm, mon_e.imm);
          check("pc", out_pc, mon_e.pc);
          check("tag", out_tag, mon_e.tag);
          pops++;
        end
      end
      if (flush) sb_q.delete();
      if (in_valid && in_ready && !flush) sb_q.push_back(model(instruction, in_pc, in_tag));
      hold_armed <= out_valid && !out_ready && !flush;
      hold_ctrl  <= {ctrl_obs, out_tag};
      hold_data  <= {imm, out_pc};
    end
  end

  task automatic send(input logic [31:0] w, input bit rnd);
    int n = 0;
    instruction = w; in_pc = pc_ctr; in_tag = tag_ctr; in_valid = 1'b1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    if (!in_ready) check("send_timeout", 64'd0, 64'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    pc_ctr  += 4;
    tag_ctr += 1;
  endtask

  task automatic present(input logic [31:0] w);
    instruction = w; in_pc = pc_ctr; in_tag = tag_ctr; in_valid = 1'b1;
  endtask

  logic [31:0] tbl [12] = '{32'h0050_0093, 32'hFE00_0EE3, 32'h0220_8033, 32'h1234_50B7,
                            32'h0000_1517, 32'h0080_00EF, 32'h0000_80E7, 32'h0011_2623,
                            32'h00C1_2083, 32'hFFF0_0093, 32'h4020_8033, 32'h0010_809B};

  initial begin
    int p0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rdy", in_ready, 0);
    check("rst_ov", out_valid, 0);
    check("rst_ctrl", ctrl_obs, 0);
    check("rst_data", {imm, out_pc, out_tag}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_rst", in_ready, 1);

    out_ready = 1'b1;
    send(32'h0050_0093, 0);
    @(negedge clk);
    check("addi_ov", out_valid, 1);
    check("addi_alu", aluCtrl, 1);
    check("addi_rd", rd, 1);
    check("addi_imm", imm, 5);
    check("addi_rw_as", {regWrite, aluSrc}, 2'b11);

    @(posedge clk); #1;
    send(32'hFE00_0EE3, 0);
    @(negedge clk);
    check("beq_branch", branch, 1);
    check("beq_imm", imm, 32'hFFFF_FFFC);

    @(posedge clk); #1;
    send(32'h0220_8033, 0);
    @(negedge clk);
    check("mul_alu", aluCtrl, MEXT ? 5'd6 : 5'd31);
    check("mul_ill", illegal, MEXT ? 1'b0 : 1'b1);

    // Backpressure: three words offered, only two fit.
    @(posedge clk); #1;
    out_ready = 1'b0;
    present(32'h0010_0113); @(posedge clk); #1; pc_ctr += 4; tag_ctr += 1;
    present(32'h0020_0193); @(posedge clk); #1; pc_ctr += 4; tag_ctr += 1;
    present(32'h0030_0213);
    @(negedge clk);
    check("full_rdy", in_ready, 0);
    check("full_ov", out_valid, 1);
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    p0 = pops;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1 check("bp_pops", pops - p0, 2);

    // Flush in ONE with an acceptable word on the input.
    out_ready = 1'b0;
    send(32'h0040_0293, 0);
    present(32'h0050_0313); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush1_ov", out_valid, 0);
    check("flush1_rdy", in_ready, 1);

    // Flush in FULL.
    @(posedge clk); #1;
    send(32'h0060_0393, 0);
    send(32'h0070_0413, 0);
    present(32'h0080_0493); flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("flush2_ov", out_valid, 0);
    check("flush2_rdy", in_ready, 1);
    p0 = pops;
    @(posedge clk); #1 out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("flush_none", pops - p0, 0);

    // Illegal opcode, then reset while holding it.
    out_ready = 1'b0;
    send(32'h0000_007F, 0);
    @(negedge clk);
    check("ill_flag", illegal, 1);
    check("ill_alu", aluCtrl, 31);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_ov", out_valid, 0);
    check("rst2_rdy", in_ready, 0);
    check("rst2_ctrl", ctrl_obs, 0);
    check("rst2_data", {imm, out_pc, out_tag}, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst2_rdy_after", in_ready, 1);
    check("rst2_ov_after", out_valid, 0);

    send(32'h0050_0090, 0);
    for (int i = 0; i < 30; i++) send(tbl[$urandom_range(0, 11)], 1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("sb_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
